// File: rtl/deb_pkg.sv
// ============================================================================
// Module : deb_pkg
// Brief  : Shared constants, index-width helper and event type for the
//          multi-channel debounce controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package deb_pkg;

  localparam int DEB_N          = 4;
  localparam int DEB_STABLE_CNT = 7;
  // Widest channel index the event type can carry (N up to 16).
  localparam int DEB_IDX_MAX_W  = 4;

  typedef struct packed {
    logic [DEB_IDX_MAX_W-1:0] idx;
    logic                     level;
  } deb_ev_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/deb_rr_arb.sv
// ============================================================================
// Module : deb_rr_arb
// Brief  : Combinational round-robin picker: first request at or after
//          last_grant+1 (mod N).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module deb_rr_arb
  import deb_pkg::*;
#(
  parameter int N     = DEB_N,
  parameter int IDX_W = clog2(DEB_N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int               w_k;
  logic [IDX_W-1:0] w_k_idx;

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    w_k       = 0;
    w_k_idx   = '0;
    for (int off = N; off >= 1; off--) begin
      w_k     = (int'(last_grant) + off) % N;
      w_k_idx = IDX_W'(w_k);
      if (req[w_k_idx]) begin
        grant_idx = w_k_idx;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/deb_scan_ctrl.sv
// ============================================================================
// Module : deb_scan_ctrl
// Brief  : Time-multiplexed N-channel debouncer with a round-robin
//          valid/ready event output. Optional DEB_OVERRUN_EN adds a sticky
//          per-channel overrun flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module deb_scan_ctrl
  import deb_pkg::*;
#(
  parameter int N          = DEB_N,
  parameter int STABLE_CNT = DEB_STABLE_CNT,
  parameter int CNT_W      = 3,
  parameter int IDX_W      = clog2(DEB_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in,
  output logic [N-1:0]     out,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_idx,
  output logic             ev_level
`ifdef DEB_OVERRUN_EN
  ,
  output logic [N-1:0]     overrun
`endif
);

  localparam logic [CNT_W-1:0] c_stable = CNT_W'(STABLE_CNT);
  localparam logic [IDX_W-1:0] c_last   = IDX_W'(N - 1);
  localparam logic [N-1:0]     c_one    = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]     r_sync1;
  logic [N-1:0]     r_sync;
  logic [IDX_W-1:0] r_scan_idx;
  logic [N-1:0]     r_smp;
  logic [N-1:0]     r_out;
  logic [N-1:0]     r_pend;
  logic [CNT_W-1:0] r_cnt [N];

  logic             r_ev_valid;
  deb_ev_t          r_ev;
  logic [IDX_W-1:0] r_last_grant;

  logic             w_sync_bit;
  logic             w_smp_bit;
  logic             w_out_bit;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_smp_chg;
  logic             w_accept;
  logic [N-1:0]     w_set;
  logic [N-1:0]     w_clr;
  logic             w_load;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_grant_vld;

  // Shared compare/count datapath, operating on the channel under scan.
  assign w_sync_bit = r_sync[r_scan_idx];
  assign w_smp_bit  = r_smp[r_scan_idx];
  assign w_out_bit  = r_out[r_scan_idx];
  assign w_cnt      = r_cnt[r_scan_idx];

  always_comb begin
    w_cnt_nxt = w_cnt;
    w_smp_chg = 1'b0;
    w_accept  = 1'b0;
    if (w_sync_bit != w_smp_bit) begin
      w_smp_chg = 1'b1;
      w_cnt_nxt = '0;
    end else if (w_cnt < c_stable) begin
      w_cnt_nxt = w_cnt + 1'b1;
      if ((w_cnt_nxt == c_stable) && (w_smp_bit != w_out_bit)) begin
        w_accept = 1'b1;
      end
    end
  end

  assign w_set = w_accept ? (c_one << r_scan_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync     <= '0;
      r_scan_idx <= '0;
      r_smp      <= '0;
      r_out      <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= in;
      r_sync     <= r_sync1;
      r_scan_idx <= (r_scan_idx == c_last) ? '0 : r_scan_idx + 1'b1;
      r_cnt[r_scan_idx] <= w_cnt_nxt;
      if (w_smp_chg) r_smp[r_scan_idx] <= w_sync_bit;
      if (w_accept)  r_out[r_scan_idx] <= w_smp_bit;
    end
  end

  deb_rr_arb #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (r_pend),
    .last_grant (r_last_grant),
    .grant_idx  (w_grant_idx),
    .grant_vld  (w_grant_vld)
  );

  assign w_load = (!r_ev_valid || ev_ready) && w_grant_vld;
  assign w_clr  = w_load ? (c_one << w_grant_idx) : '0;

  // A fresh accept on the channel being granted keeps its pending bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= '0;
      r_ev_valid   <= 1'b0;
      r_ev         <= '0;
      r_last_grant <= c_last;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_load) begin
        r_ev_valid   <= 1'b1;
        r_ev.idx     <= DEB_IDX_MAX_W'(w_grant_idx);
        r_ev.level   <= r_out[w_grant_idx];
        r_last_grant <= w_grant_idx;
      end else if (ev_ready) begin
        r_ev_valid <= 1'b0;
      end
    end
  end

`ifdef DEB_OVERRUN_EN
  logic [N-1:0] r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= r_overrun | (w_set & r_pend & ~w_clr);
    end
  end

  assign overrun = r_overrun;
`endif

  logic unused_ev_idx;
  assign unused_ev_idx = ^r_ev.idx;

  assign out      = r_out;
  assign ev_valid = r_ev_valid;
  assign ev_idx   = r_ev.idx[IDX_W-1:0];
  assign ev_level = r_ev.level;

endmodule

`default_nettype wire

// File: tb/tb_deb_scan_ctrl.sv
// Directed self-checking bench for deb_scan_ctrl (N=4, STABLE_CNT=7).
`default_nettype none

module tb_deb_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic [3:0] out;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_idx;
  logic       ev_level;
`ifdef DEB_OVERRUN_EN
  logic [3:0] overrun;
`endif

  int checks;
  int errors;

  deb_scan_ctrl #(
    .N          (4),
    .STABLE_CNT (7),
    .CNT_W      (3),
    .IDX_W      (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (din),
    .out      (out),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_idx   (ev_idx),
    .ev_level (ev_level)
`ifdef DEB_OVERRUN_EN
    ,
    .overrun  (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ev_valid && n < 60);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    din      = 4'b0000;
    ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({out, ev_valid, ev_idx, ev_level} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got out=%b v=%b idx=%0d lvl=%b want all 0", out, ev_valid, ev_idx, ev_level);
    end
`ifdef DEB_OVERRUN_EN
    checks++;
    if (overrun !== 4'b0000) begin
      errors++;
      $display("FAIL reset_overrun got %b want 0000", overrun);
    end
`endif
  endtask

  task automatic test_clean_step();
    int n;
    din[1] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out[1] && n < 60);
    checks++;
    if (n < 30 || n > 34) begin
      errors++;
      $display("FAIL clean_latency got %0d want 30..34", n);
    end
    checks++;
    if (out !== 4'b0010) begin
      errors++;
      $display("FAIL clean_out got %b want 0010", out);
    end
    tick();
    checks++;
    if ({ev_valid, ev_idx, ev_level} !== {1'b1, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL clean_event got v=%b idx=%0d lvl=%b want 1/1/1", ev_valid, ev_idx, ev_level);
    end
    tick();
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_single got v=%b want 0", ev_valid);
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    din[2] = 1'b1;
    repeat (20) begin
      tick();
      if (ev_valid !== 1'b0 || out !== 4'b0010) bad++;
    end
    din[2] = 1'b0;
    repeat (100) begin
      tick();
      if (ev_valid !== 1'b0 || out !== 4'b0010) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_reject got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_release();
    int n;
    din[1] = 1'b0;
    wait_valid(n);
    checks++;
    if (n > 36) begin
      errors++;
      $display("FAIL release_latency got %0d want <=36", n);
    end
    checks++;
    if ({ev_valid, ev_idx, ev_level, out} !== {1'b1, 2'd1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL release_event got v=%b idx=%0d lvl=%b out=%b want 1/1/0/0000", ev_valid, ev_idx, ev_level, out);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    ev_ready = 1'b0;
    din[0]   = 1'b1;
    repeat (4) tick();
    din[2] = 1'b1;
    wait_valid(n);
    checks++;
    if ({ev_valid, ev_idx, ev_level} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL bp_first got v=%b idx=%0d lvl=%b want 1/0/1", ev_valid, ev_idx, ev_level);
    end
    bad = 0;
    repeat (50) begin
      tick();
      if ({ev_valid, ev_idx, ev_level} !== {1'b1, 2'd0, 1'b1}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    ev_ready = 1'b1;
    tick();
    checks++;
    if ({ev_valid, ev_idx, ev_level} !== {1'b1, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL bp_second got v=%b idx=%0d lvl=%b want 1/2/1", ev_valid, ev_idx, ev_level);
    end
    tick();
    checks++;
    if ({ev_valid, out} !== {1'b0, 4'b0101}) begin
      errors++;
      $display("FAIL bp_drain got v=%b out=%b want 0/0101", ev_valid, out);
    end
  endtask

  task automatic test_round_robin();
    int n;
    ev_ready = 1'b0;
    din[2]   = 1'b0;
    wait_valid(n);
    checks++;
    if ({ev_valid, ev_idx, ev_level} !== {1'b1, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL rr_hold_evt got v=%b idx=%0d lvl=%b want 1/2/0", ev_valid, ev_idx, ev_level);
    end
    din[0] = 1'b0;
    din[3] = 1'b1;
    repeat (45) tick();
    ev_ready = 1'b1;
    tick();
    checks++;
    if ({ev_valid, ev_idx, ev_level} !== {1'b1, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL rr_first got v=%b idx=%0d lvl=%b want 1/3/1", ev_valid, ev_idx, ev_level);
    end
    tick();
    checks++;
    if ({ev_valid, ev_idx, ev_level} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL rr_second got v=%b idx=%0d lvl=%b want 1/0/0", ev_valid, ev_idx, ev_level);
    end
    tick();
    checks++;
    if ({ev_valid, out} !== {1'b0, 4'b1000}) begin
      errors++;
      $display("FAIL rr_drain got v=%b out=%b want 0/1000", ev_valid, out);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    int bad;
    ev_ready = 1'b0;
    din[1]   = 1'b1;
    wait_valid(n);
    din[3] = 1'b0;
    repeat (24) tick();
    checks++;
    if ({ev_valid, out} !== {1'b1, 4'b1010}) begin
      errors++;
      $display("FAIL midop_pre got v=%b out=%b want 1/1010", ev_valid, out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out, ev_valid, ev_idx, ev_level} !== 8'h00) begin
      errors++;
      $display("FAIL midop_async got out=%b v=%b idx=%0d lvl=%b want all 0", out, ev_valid, ev_idx, ev_level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      tick();
      if (out !== 4'b0000 || ev_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midop_stale got %0d bad cycles want 0", bad);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!out[1] && n < 10);
    checks++;
    if (out !== 4'b0010) begin
      errors++;
      $display("FAIL midop_restep got out=%b want 0010", out);
    end
    tick();
    checks++;
    if ({ev_valid, ev_idx, ev_level} !== {1'b1, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL midop_event got v=%b idx=%0d lvl=%b want 1/1/1", ev_valid, ev_idx, ev_level);
    end
    ev_ready = 1'b1;
    repeat (3) tick();
  endtask

`ifdef DEB_OVERRUN_EN
  task automatic test_overrun();
    int n;
    ev_ready = 1'b0;
    din[0]   = 1'b1;
    wait_valid(n);
    din[0] = 1'b0;
    repeat (40) tick();
    din[0] = 1'b1;
    repeat (40) tick();
    checks++;
    if ({overrun, ev_valid, ev_idx} !== {4'b0001, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL overrun_set got ovr=%b v=%b idx=%0d want 0001/1/0", overrun, ev_valid, ev_idx);
    end
    ev_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (overrun !== 4'b0001) begin
      errors++;
      $display("FAIL overrun_sticky got %b want 0001", overrun);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (overrun !== 4'b0000) begin
      errors++;
      $display("FAIL overrun_clear got %b want 0000", overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_release();
    test_backpressure();
    test_round_robin();
    test_reset_midop();
`ifdef DEB_OVERRUN_EN
    test_overrun();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
